// File: rtl/ccff_chain_sequencer_pkg.sv
// ccff_seq_pkg: sequencer state encoding and mode constants shared by the chain sequencer files
package ccff_seq_pkg;
  typedef enum logic [1:0] {IDLE, PROG, READBACK, FINISH} seq_state_e;
  localparam logic MODE_PROG     = 1'b0;
  localparam logic MODE_READBACK = 1'b1;
endpackage

// File: rtl/ccff_chain_sequencer_if.sv
// ccff_chain_sequencer_if: command, stream and chain-pin bundle between the tile DMA side and one sequencer
interface ccff_chain_sequencer_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic              mode;
  logic              abort;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              config_enable;
  logic              config_readback;
  logic              busy;
  logic              done;
  modport master (
    output start, mode, abort, s_data, s_valid, m_ready, ccff_tail,
    input  s_ready, m_data, m_valid, ccff_head, config_enable, config_readback, busy, done
  );
  modport slave (
    input  start, mode, abort, s_data, s_valid, m_ready, ccff_tail,
    output s_ready, m_data, m_valid, ccff_head, config_enable, config_readback, busy, done
  );
endinterface

// File: rtl/ccff_word_serdes.sv
// ccff_word_serdes: WORD_W shift/pack register with bit index; serializer in PROG, deserializer in READBACK
module ccff_word_serdes #(
  parameter int WORD_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_load,
  input  logic [WORD_W-1:0]            i_d,
  input  logic                         i_step,
  input  logic                         i_cap,
  input  logic                         i_bit,
  output logic                         o_bit,
  output logic [WORD_W-1:0]            o_packed,
  output logic [$clog2(WORD_W+1)-1:0]  o_idx
);
  localparam int IW = $clog2(WORD_W + 1);
  logic [WORD_W-1:0] r_word;
  logic [IW-1:0]     r_idx;
  assign o_bit    = |(r_word & (WORD_W'(1) << r_idx));
  assign o_packed = r_word | (WORD_W'(i_bit) << r_idx);
  assign o_idx    = r_idx;
  always_ff @(posedge clk)
    if (rst || i_clr) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_word <= i_d;
      r_idx  <= '0;
    end else if (i_step) begin
      r_word <= i_cap ? o_packed : r_word;
      r_idx  <= r_idx + IW'(1);
    end
endmodule

// File: rtl/ccff_chain_sequencer.sv
// ccff_chain_sequencer: programs a CLB configuration chain from a word stream, or rotates it
// non-destructively and streams the tail bits back out as words
module ccff_chain_sequencer
  import ccff_seq_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  ccff_chain_sequencer_if.slave bus
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] ALL_BITS = CW'(CHAIN_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W - 1);
  seq_state_e        r_state;
  logic [CW-1:0]     r_bit_cnt;
  logic              r_full;
  logic              r_m_valid;
  logic [WORD_W-1:0] r_m_data;
  logic [WORD_W-1:0] w_packed;
  logic [IW-1:0]     w_idx;
  logic              w_bit, w_prog, w_rb, w_last, w_shift_p, w_shift_r;
  logic              w_buf_done, w_word_done, w_s_ready, w_acc;
  assign w_prog      = r_state == PROG && !bus.abort;
  assign w_rb        = r_state == READBACK && !bus.abort;
  assign w_last      = r_bit_cnt == LAST_BIT;
  assign w_shift_p   = w_prog && r_full;
  assign w_shift_r   = w_rb && r_bit_cnt != ALL_BITS && (!r_m_valid || bus.m_ready);
  assign w_buf_done  = w_shift_p && (w_idx == LAST_IDX || w_last);
  assign w_word_done = w_shift_r && (w_idx == LAST_IDX || w_last);
  // Ready while the last buffered bit shifts keeps back-to-back words bubble-free; never on the final shift.
  assign w_s_ready   = w_prog && (!r_full || w_buf_done) && !(w_shift_p && w_last);
  assign w_acc       = w_s_ready && bus.s_valid;
  assign bus.s_ready         = w_s_ready;
  assign bus.config_enable   = w_shift_p || w_shift_r;
  assign bus.ccff_head       = (r_state == READBACK) ? bus.ccff_tail : (w_shift_p && w_bit);
  assign bus.config_readback = r_state == READBACK;
  assign bus.busy            = r_state != IDLE;
  assign bus.done            = r_state == FINISH;
  assign bus.m_data          = r_m_data;
  assign bus.m_valid         = r_m_valid;
  ccff_word_serdes #(.WORD_W(WORD_W)) u_serdes (
    .clk      (prog_clk),
    .rst      (pReset),
    .i_clr    (bus.abort || r_state == IDLE || w_word_done),
    .i_load   (w_acc),
    .i_d      (bus.s_data),
    .i_step   (w_shift_p || w_shift_r),
    .i_cap    (w_shift_r),
    .i_bit    (bus.ccff_tail),
    .o_bit    (w_bit),
    .o_packed (w_packed),
    .o_idx    (w_idx)
  );
  always_ff @(posedge prog_clk)
    if (pReset || bus.abort) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_full    <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      r_bit_cnt <= (r_state == IDLE) ? '0 : r_bit_cnt + CW'(w_shift_p || w_shift_r);
      r_full    <= w_acc || (r_full && !w_buf_done);
      r_m_valid <= w_word_done || (r_m_valid && !bus.m_ready);
      r_m_data  <= w_word_done ? w_packed : r_m_data;
      case (r_state)
        IDLE:     r_state <= bus.start ? (bus.mode == MODE_READBACK ? READBACK : PROG) : IDLE;
        PROG:     r_state <= (w_shift_p && w_last) ? FINISH : PROG;
        READBACK: r_state <= (r_m_valid && bus.m_ready && r_bit_cnt == ALL_BITS) ? FINISH : READBACK;
        default:  r_state <= IDLE;
      endcase
    end
endmodule

// File: doc/ccff_chain_sequencer.md
Name: ccff_chain_sequencer

Overview:
- Sequences the configuration-chain shift register of one CLB tile, e.g. the frac_logic chain: frac_lut4_arith bits followed by output-mux mem bits.
- Program mode: takes bitstream words over a valid/ready stream, serializes them LSB-first onto the chain head and pulses config_enable per shift.
- Readback mode: rotates the chain non-destructively, tail to head, and packs tail bits into output words.
- Sits between the tile-level bitstream DMA and the tile's ccff_head/ccff_tail pins; one instance per chain.

Parameters:
- CHAIN_LEN, 20, number of flops in the chain (1..4096).
- WORD_W, 8, stream word width in bits (1..32).

Ports:
- prog_clk  in  1  configuration clock; all state on rising edge.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse; ignored unless busy=0.
- mode  in  1  sampled with start: 0=program, 1=readback.
- abort  in  1  returns to IDLE next cycle from any state.
- s_data  in  WORD_W  program word; bit 0 shifted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid&s_ready.
- m_data  out  WORD_W  readback word; bit 0 = first tail bit captured.
- m_valid  out  1  m_data valid; held until m_ready.
- m_ready  in  1  consumer accepts m_data.
- ccff_head  out  1  serial data into chain.
- ccff_tail  in  1  serial data out of chain.
- config_enable  out  1  chain shifts on a prog_clk edge where this is 1.
- config_readback  out  1  high throughout READBACK state.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on normal completion; not asserted on abort.

Behaviour:
- Reset (pReset=1 at edge): state=IDLE; all counters 0; s_ready, m_valid, config_enable, config_readback, busy, done, ccff_head all 0; m_data 0.
- States: IDLE, PROG, READBACK, FINISH.
- IDLE: start&!mode -> PROG; start&mode -> READBACK. bit_cnt=0; word buffer empty.
- PROG:
  - Single-word buffer sh_word, plus bit index bidx.
  - s_ready=1 iff buffer empty; accepted word loads the buffer; bidx=0.
  - Shift cycle (config_enable=1) iff buffer full. ccff_head=sh_word[bidx]. bidx++, bit_cnt++.
  - Buffer empties when bidx reaches WORD_W-1 or bit_cnt reaches CHAIN_LEN-1.
  - Empty buffer -> stall: config_enable=0, ccff_head=0, no shift.
  - After shift number CHAIN_LEN -> FINISH.
  - Unused high bits of the final word are discarded.
  - Word count = ceil(CHAIN_LEN/WORD_W).
  - Min latency CHAIN_LEN+1 cycles from start to done with s_valid held high.
  - No-bubble requirement: s_ready is combinationally asserted in the cycle the last bit of the buffer shifts, so back-to-back words give one shift per cycle.
- READBACK:
  - config_readback=1; ccff_head=ccff_tail (rotation, chain contents preserved after CHAIN_LEN shifts).
  - Shift cycle iff output word register not full-and-pending (m_valid=0 or m_ready=1 this cycle).
  - Each shift captures ccff_tail into pack[pidx]; pidx++, bit_cnt++.
  - Pack is presented on m_data with m_valid=1 when pidx reaches WORD_W or bit_cnt reaches CHAIN_LEN; unused high bits are 0.
  - With m_valid=1 and m_ready=0: shifting stalls (config_enable=0), m_data stable.
  - After the final word handshakes -> FINISH.
- FINISH: done=1 for one cycle; busy=1; then IDLE.
- config_enable is never 1 outside PROG/READBACK shift cycles.
- abort: takes precedence over all other inputs. Next state is IDLE with the reset values, except that the chain contents are left as-is. A pending m_valid is dropped. A partially consumed input word is discarded.
- start while busy: ignored, no error flag.
- Simultaneous s_valid handshake and final shift: the word is not accepted (s_ready=0 once bit_cnt=CHAIN_LEN-1 is shifting with buffer becoming empty).
- bit_cnt width $clog2(CHAIN_LEN+1); bidx/pidx width $clog2(WORD_W+1); no wrap occurs within legal parameters.

Decomposition:
- Shared package ccff_seq_pkg: state enum (IDLE/PROG/READBACK/FINISH) and MODE_PROG/MODE_READBACK constants.
- One natural sub-module: ccff_word_serdes, the shared WORD_W shift/pack register with index counter, used as serializer in PROG and deserializer in READBACK.
- FSM and bit counter stay in the top.

Test Plan:
- Program, CHAIN_LEN=20, WORD_W=8, words 0xA5,0x3C,0xF9 with s_valid held -> 20 consecutive config_enable cycles. Head sequence: 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,0,1. done at cycle 21. Chain model holds the loaded 20 bits.
- Program with s_valid deasserted 3 cycles between words -> config_enable=0 and no shift during gaps; final chain contents identical to previous test.
- Readback after the first test, m_ready=1 -> m_data 0xA5, 0x3C, 0x09. Chain contents unchanged afterwards. config_readback=1 for all 20 shifts.
- Readback with m_ready=0 for 5 cycles at first word -> m_data=0xA5 held stable; exactly 8 shifts before the stall, then resume; totals match.
- abort after 10 program shifts -> next cycle IDLE, busy=0, config_enable=0, no done. A new start programs 20 bits correctly.
- pReset asserted mid-READBACK and start asserted while busy -> all outputs 0 after reset edge; the start-while-busy pulse causes no state change.
